// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result bus of the pipelined CLA adder/subtractor.
// Both sides use valid/ready: a beat moves only on a cycle where valid and ready are both high; the producer holds its beat stable until then.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, cin, mode, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, a, b, cin, mode, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: STAGES slices of WIDTH/STAGES bits, LSB slice first,
// each built from GROUP-bit lookahead blocks, with saturation and result flags in the last stage.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_cla_addsub_if.slave bus
);
    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / GROUP;
    localparam int L  = STAGES - 1;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ADC = 2'b10;
    localparam logic [1:0] MODE_SAT = 2'b11;

    // Returns {carry out, carry into top bit, slice sum}; every carry is a flat sum of products.
    function automatic logic [SW+1:0] cla_slice(input logic [SW-1:0] x,
                                                input logic [SW-1:0] y,
                                                input logic          c0);
        logic [SW-1:0] p, g, c;
        logic [NG-1:0] gp, gg;
        logic [NG:0]   bc;
        logic          acc, term;
        p = x ^ y;
        g = x & y;
        for (int j = 0; j < NG; j++) begin
            gp[j] = 1'b1;
            gg[j] = 1'b0;
            for (int i = 0; i < GROUP; i++) begin
                gp[j] = gp[j] & p[j*GROUP+i];
                term  = g[j*GROUP+i];
                for (int t = i + 1; t < GROUP; t++) term = term & p[j*GROUP+t];
                gg[j] = gg[j] | term;
            end
        end
        for (int j = 0; j <= NG; j++) begin
            acc = c0;
            for (int t = 0; t < j; t++) acc = acc & gp[t];
            for (int i = 0; i < j; i++) begin
                term = gg[i];
                for (int t = i + 1; t < j; t++) term = term & gp[t];
                acc = acc | term;
            end
            bc[j] = acc;
        end
        for (int j = 0; j < NG; j++) begin
            for (int t = 0; t < GROUP; t++) begin
                acc = bc[j];
                for (int u = 0; u < t; u++) acc = acc & p[j*GROUP+u];
                for (int i = 0; i < t; i++) begin
                    term = g[j*GROUP+i];
                    for (int u = i + 1; u < t; u++) term = term & p[j*GROUP+u];
                    acc = acc | term;
                end
                c[j*GROUP+t] = acc;
            end
        end
        return {bc[NG], c[SW-1], p ^ c};
    endfunction

    // Stage registers; index L is the visible output register.
    logic [WIDTH-1:0] a_r [STAGES];
    logic [WIDTH-1:0] b_r [STAGES];
    logic [WIDTH-1:0] s_r [STAGES];
    logic [1:0]       m_r [STAGES];
    logic             c_r [STAGES];
    logic             t_r [STAGES];
    logic             v_r [STAGES];
    logic             zero_r, neg_r;

    // Inputs seen by each stage: the prepared beat for stage 0, the previous register otherwise.
    logic [WIDTH-1:0] pr_a [STAGES];
    logic [WIDTH-1:0] pr_b [STAGES];
    logic [WIDTH-1:0] pr_s [STAGES];
    logic [1:0]       pr_m [STAGES];
    logic             pr_c [STAGES];
    logic             pr_v [STAGES];

    logic [WIDTH-1:0] nx_s [STAGES];
    logic             nx_c [STAGES];
    logic             nx_t [STAGES];

    logic             adv;
    logic             ovf_n;
    logic [WIDTH-1:0] fin_sum;

    assign pr_a[0] = bus.a;
    assign pr_b[0] = (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
    assign pr_s[0] = '0;
    assign pr_m[0] = bus.mode;
    assign pr_c[0] = (bus.mode == MODE_SUB) ? 1'b1 : ((bus.mode == MODE_ADC) ? bus.cin : 1'b0);
    assign pr_v[0] = bus.in_valid;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign pr_a[k] = a_r[k-1];
        assign pr_b[k] = b_r[k-1];
        assign pr_s[k] = s_r[k-1];
        assign pr_m[k] = m_r[k-1];
        assign pr_c[k] = c_r[k-1];
        assign pr_v[k] = v_r[k-1];
    end

    always_comb begin
        logic [SW+1:0] r;
        for (int k = 0; k < STAGES; k++) begin
            r                  = cla_slice(pr_a[k][k*SW +: SW], pr_b[k][k*SW +: SW], pr_c[k]);
            nx_s[k]            = pr_s[k];
            nx_s[k][k*SW +: SW] = r[SW-1:0];
            nx_t[k]            = r[SW];
            nx_c[k]            = r[SW+1];
        end
    end

    // Saturation only for mode 11; ovf and cout stay the raw adder values in every mode.
    always_comb begin
        ovf_n   = nx_t[L] ^ nx_c[L];
        fin_sum = nx_s[L];
        if (pr_m[L] == MODE_SAT && ovf_n)
            fin_sum = pr_a[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    assign adv = !v_r[L] || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
                m_r[k] <= MODE_ADD;
                c_r[k] <= 1'b0;
                t_r[k] <= 1'b0;
                v_r[k] <= 1'b0;
            end
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= pr_a[k];
                b_r[k] <= pr_b[k];
                s_r[k] <= (k == L) ? fin_sum : nx_s[k];
                m_r[k] <= pr_m[k];
                c_r[k] <= nx_c[k];
                t_r[k] <= (k == L) ? ovf_n : nx_t[k];
                v_r[k] <= pr_v[k];
            end
            zero_r <= (fin_sum == '0);
            neg_r  <= fin_sum[WIDTH-1];
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = v_r[L];
    assign bus.sum       = s_r[L];
    assign bus.cout      = c_r[L];
    assign bus.ovf       = t_r[L];
    assign bus.zero      = zero_r;
    assign bus.neg       = neg_r;
endmodule
